// File: rtl/wb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_mem_arbiter
//  Purpose  : Two-master Wishbone arbiter in front of a single memory adapter
//             slave port. Grants are round-robin and held for a whole bus
//             cycle (while the owner's cyc stays high). A new grant is only
//             issued while the adapter reports not busy, so posted writes
//             drain before the port changes hands. A watchdog terminates a
//             stalled cycle with a one-cycle error response.
//
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             m0_* / m1_*         - Wishbone master ports (cyc, stb, we, addr,
//                                   cti, bte, sel, write data in; read data,
//                                   ack, err out)
//             s_*                 - Wishbone port towards the memory adapter
//             s_busy_i            - adapter busy (write-back still pending)
//             grant               - one-hot current owner, 00 when none
//
//  Revision : 1.0 - initial release
// ============================================================================
module wb_mem_arbiter #(
    parameter int TIMEOUT  = 1024,
    parameter int CNT_BITS = 10
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [31:2] m0_addr_i,
    input  logic [2:0]  m0_cti_i,
    input  logic [1:0]  m0_bte_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_data_i,
    output logic [31:0] m0_data_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [31:2] m1_addr_i,
    input  logic [2:0]  m1_cti_i,
    input  logic [1:0]  m1_bte_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_data_i,
    output logic [31:0] m1_data_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,

    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:2] s_addr_o,
    output logic [2:0]  s_cti_o,
    output logic [1:0]  s_bte_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_data_o,
    input  logic [31:0] s_data_i,
    input  logic        s_ack_i,
    input  logic        s_busy_i,

    output logic [1:0]  grant
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT0  = 2'd1,
        ST_GNT1  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [CNT_BITS-1:0] c_CNT_MAX = CNT_BITS'(TIMEOUT - 1);

    state_t              r_state;
    logic                r_last;    // master served most recently
    logic [CNT_BITS-1:0] r_cnt;     // stalled-strobe watchdog count

    logic w_own0;
    logic w_own1;
    logic w_cyc;
    logic w_stb;
    logic w_stall;
    logic w_fire;

    // Ownership is qualified by rst so the reset cycle itself already shows
    // a quiet bus, whatever state the register still holds.
    assign w_own0 = !rst && (r_state == ST_GNT0);
    assign w_own1 = !rst && (r_state == ST_GNT1);

    assign w_cyc = w_own0 ? m0_cyc_i : (w_own1 ? m1_cyc_i : 1'b0);
    assign w_stb = w_own0 ? m0_stb_i : (w_own1 ? m1_stb_i : 1'b0);

    // A strobe the slave has not acknowledged this cycle.
    assign w_stall = w_cyc && w_stb && !s_ack_i;
    // An ack in the firing cycle keeps w_stall low, so the ack wins.
    assign w_fire  = w_stall && (r_cnt == c_CNT_MAX);

    // ------------------------------------------------------------------
    // Combinational signal routing from the registered owner
    // ------------------------------------------------------------------
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_addr_o = '0;
        s_cti_o  = '0;
        s_bte_o  = '0;
        s_sel_o  = '0;
        s_data_o = '0;
        // Everything towards the slave is gated by the owner's cyc, so the
        // cycle in which cyc drops already presents an idle bus.
        if (w_own0 && m0_cyc_i) begin
            s_cyc_o  = 1'b1;
            s_stb_o  = m0_stb_i;
            s_we_o   = m0_we_i;
            s_addr_o = m0_addr_i;
            s_cti_o  = m0_cti_i;
            s_bte_o  = m0_bte_i;
            s_sel_o  = m0_sel_i;
            s_data_o = m0_data_i;
        end else if (w_own1 && m1_cyc_i) begin
            s_cyc_o  = 1'b1;
            s_stb_o  = m1_stb_i;
            s_we_o   = m1_we_i;
            s_addr_o = m1_addr_i;
            s_cti_o  = m1_cti_i;
            s_bte_o  = m1_bte_i;
            s_sel_o  = m1_sel_i;
            s_data_o = m1_data_i;
        end
    end

    assign grant     = {w_own1, w_own0};
    assign m0_ack_o  = w_own0 && s_ack_i;
    assign m1_ack_o  = w_own1 && s_ack_i;
    assign m0_err_o  = w_own0 && w_fire;
    assign m1_err_o  = w_own1 && w_fire;
    assign m0_data_o = s_data_i;
    assign m1_data_o = s_data_i;

    // ------------------------------------------------------------------
    // Ownership state, round-robin pointer and watchdog
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_last  <= 1'b1;        // m0 wins the first tie
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (!s_busy_i) begin
                        if (m0_cyc_i && m1_cyc_i) begin
                            if (r_last) begin
                                r_state <= ST_GNT0;
                                r_last  <= 1'b0;
                            end else begin
                                r_state <= ST_GNT1;
                                r_last  <= 1'b1;
                            end
                        end else if (m0_cyc_i) begin
                            r_state <= ST_GNT0;
                            r_last  <= 1'b0;
                        end else if (m1_cyc_i) begin
                            r_state <= ST_GNT1;
                            r_last  <= 1'b1;
                        end
                    end
                end

                ST_GNT0, ST_GNT1: begin
                    if (w_fire || !w_cyc) begin
                        r_state <= ST_DRAIN;
                        r_cnt   <= '0;
                    end else if (w_stall) begin
                        // Saturating; the fire path above normally leaves first.
                        if (r_cnt != c_CNT_MAX) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else begin
                        r_cnt <= '0;
                    end
                end

                ST_DRAIN: begin
                    r_cnt <= '0;
                    if (!s_busy_i) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_mem_arbiter
//  Purpose  : Self-checking bench for wb_mem_arbiter. A cycle table covers the
//             directed scenarios; a randomized phase is checked against a
//             behavioural owner/drain/round-robin model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_mem_arbiter;

    localparam int TIMEOUT  = 8;
    localparam int CNT_BITS = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        mc   [2];
    logic        ms   [2];
    logic        mw   [2];
    logic [29:0] ma   [2];
    logic [2:0]  mcti [2];
    logic [1:0]  mbte [2];
    logic [3:0]  msel [2];
    logic [31:0] md   [2];

    logic [31:0] m0_data_o, m1_data_o;
    logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [29:0] s_addr_o;
    logic [2:0]  s_cti_o;
    logic [1:0]  s_bte_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_data_o;
    logic [31:0] s_data_i;
    logic        s_ack_i, s_busy_i;
    logic [1:0]  grant;

    wb_mem_arbiter #(.TIMEOUT(TIMEOUT), .CNT_BITS(CNT_BITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_cyc_i  (mc[0]),
        .m0_stb_i  (ms[0]),
        .m0_we_i   (mw[0]),
        .m0_addr_i (ma[0]),
        .m0_cti_i  (mcti[0]),
        .m0_bte_i  (mbte[0]),
        .m0_sel_i  (msel[0]),
        .m0_data_i (md[0]),
        .m0_data_o (m0_data_o),
        .m0_ack_o  (m0_ack_o),
        .m0_err_o  (m0_err_o),
        .m1_cyc_i  (mc[1]),
        .m1_stb_i  (ms[1]),
        .m1_we_i   (mw[1]),
        .m1_addr_i (ma[1]),
        .m1_cti_i  (mcti[1]),
        .m1_bte_i  (mbte[1]),
        .m1_sel_i  (msel[1]),
        .m1_data_i (md[1]),
        .m1_data_o (m1_data_o),
        .m1_ack_o  (m1_ack_o),
        .m1_err_o  (m1_err_o),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_we_o    (s_we_o),
        .s_addr_o  (s_addr_o),
        .s_cti_o   (s_cti_o),
        .s_bte_o   (s_bte_o),
        .s_sel_o   (s_sel_o),
        .s_data_o  (s_data_o),
        .s_data_i  (s_data_i),
        .s_ack_i   (s_ack_i),
        .s_busy_i  (s_busy_i),
        .grant     (grant)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // One table row = one clock cycle: inputs held for the cycle, outputs
    // expected while they are held. stb follows cyc for both masters.
    typedef struct packed {
        logic       rst;
        logic       c0;
        logic       c1;
        logic       ack;
        logic       busy;
        logic [1:0] g;
        logic       scyc;
        logic       a0;
        logic       a1;
        logic       e0;
        logic       e1;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [4:0] ins, input logic [1:0] g, input logic [4:0] outs);
        tbl.push_back(vec_t'({ins, g, outs}));
    endtask

    // ------------------------------------------------------------------
    // Behavioural reference: who owns the port, whether the port is
    // draining, who was served last and how long the owner has stalled.
    // ------------------------------------------------------------------
    int m_owner;   // -1 none, else master index
    bit m_drain;
    int m_last;
    int m_stall;

    function automatic logic [143:0] model_out();
        logic [1:0]  g   = '0;
        logic        sc  = 1'b0, ss = 1'b0, sw = 1'b0;
        logic [29:0] sa  = '0;
        logic [2:0]  sct = '0;
        logic [1:0]  sbt = '0;
        logic [3:0]  ssl = '0;
        logic [31:0] sd  = '0;
        logic [1:0]  ak  = '0, er = '0;
        if (!rst && !m_drain && m_owner >= 0) begin
            int x;
            x = m_owner;
            g[x] = 1'b1;
            if (mc[x]) begin
                sc = 1'b1; ss = ms[x]; sw = mw[x]; sa = ma[x];
                sct = mcti[x]; sbt = mbte[x]; ssl = msel[x]; sd = md[x];
            end
            ak[x] = s_ack_i;
            er[x] = mc[x] && ms[x] && !s_ack_i && (m_stall == TIMEOUT - 1);
        end
        return {g, sc, ss, sw, sa, sct, sbt, ssl, sd, s_data_i, s_data_i,
                ak[0], ak[1], er[0], er[1]};
    endfunction

    task automatic model_step();
        if (rst) begin
            m_owner = -1; m_drain = 1'b0; m_last = 1; m_stall = 0;
        end else if (m_drain) begin
            if (!s_busy_i) m_drain = 1'b0;
        end else if (m_owner < 0) begin
            if (!s_busy_i && (mc[0] || mc[1])) begin
                int w;
                if (mc[0] && mc[1]) w = 1 - m_last;
                else                w = mc[0] ? 0 : 1;
                m_owner = w; m_last = w; m_stall = 0;
            end
        end else begin
            int x;
            bit fire;
            x = m_owner;
            fire = mc[x] && ms[x] && !s_ack_i && (m_stall == TIMEOUT - 1);
            if (fire || !mc[x]) begin
                m_owner = -1; m_drain = 1'b1; m_stall = 0;
            end else if (ms[x] && !s_ack_i) begin
                m_stall = (m_stall + 1 > TIMEOUT - 1) ? TIMEOUT - 1 : m_stall + 1;
            end else begin
                m_stall = 0;
            end
        end
    endtask

    function automatic logic [143:0] dut_out();
        return {grant, s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_cti_o, s_bte_o,
                s_sel_o, s_data_o, m0_data_o, m1_data_o,
                m0_ack_o, m1_ack_o, m0_err_o, m1_err_o};
    endfunction

    initial begin
        logic [103:0] t_exp, t_act;
        logic [143:0] r_exp, r_act;
        int           ack_pct;

        rst = 1'b1; s_ack_i = 1'b0; s_busy_i = 1'b0; s_data_i = 32'hCAFEF00D;
        for (int x = 0; x < 2; x++) begin
            mc[x] = 1'b0; ms[x] = 1'b0; mw[x] = 1'b0; ma[x] = '0;
            mcti[x] = '0; mbte[x] = '0; msel[x] = '0; md[x] = '0;
        end

        // rst c0 c1 ack busy | grant | s_cyc ack0 ack1 err0 err1
        add(5'b10000, 2'b00, 5'b00000);     // reset
        add(5'b01000, 2'b00, 5'b00000);     // m0 write: cyc rises
        add(5'b01000, 2'b01, 5'b10000);
        add(5'b01000, 2'b01, 5'b10000);
        add(5'b01011, 2'b01, 5'b11000);     // ack 2 cycles after stb, busy
        add(5'b00001, 2'b01, 5'b00000);     // cyc drops -> slave gated
        add(5'b00001, 2'b00, 5'b00000);     // drain while busy
        add(5'b00000, 2'b00, 5'b00000);
        add(5'b00000, 2'b00, 5'b00000);
        add(5'b10000, 2'b00, 5'b00000);     // reset, then both request
        add(5'b01100, 2'b00, 5'b00000);
        add(5'b01110, 2'b01, 5'b11000);     // m0 first
        add(5'b00100, 2'b01, 5'b00000);
        add(5'b00100, 2'b00, 5'b00000);
        add(5'b00100, 2'b00, 5'b00000);
        add(5'b00110, 2'b10, 5'b10100);     // then m1
        add(5'b00000, 2'b10, 5'b00000);
        add(5'b00000, 2'b00, 5'b00000);
        add(5'b01100, 2'b00, 5'b00000);     // same stimulus again
        add(5'b01110, 2'b01, 5'b11000);     // m0 first again
        add(5'b00000, 2'b01, 5'b00000);
        add(5'b00000, 2'b00, 5'b00000);
        add(5'b01000, 2'b00, 5'b00000);     // m0 stalls, m1 pending
        add(5'b01000, 2'b01, 5'b10000);     // stalled cycle 1
        for (int i = 0; i < 6; i++) add(5'b01100, 2'b01, 5'b10000);
        add(5'b01100, 2'b01, 5'b10010);     // stalled cycle 8: err
        add(5'b01100, 2'b00, 5'b00000);     // drain
        add(5'b01100, 2'b00, 5'b00000);     // m1 wins tie
        add(5'b01110, 2'b10, 5'b10100);
        add(5'b01000, 2'b10, 5'b00000);
        add(5'b01000, 2'b00, 5'b00000);
        add(5'b01000, 2'b00, 5'b00000);
        add(5'b01111, 2'b01, 5'b11000);     // m0 acked, busy starts
        add(5'b00101, 2'b01, 5'b00000);
        for (int i = 0; i < 3; i++) add(5'b00101, 2'b00, 5'b00000);
        add(5'b00100, 2'b00, 5'b00000);     // busy drops
        add(5'b00100, 2'b00, 5'b00000);
        add(5'b00110, 2'b10, 5'b10100);     // m1 burst beat
        add(5'b10110, 2'b00, 5'b00000);     // reset mid-burst
        add(5'b00100, 2'b00, 5'b00000);     // back in IDLE
        add(5'b00100, 2'b10, 5'b10000);

        ma[0] = 30'h400;  mw[0] = 1'b1; md[0] = 32'hDEADBEEF; msel[0] = 4'hF;
        ma[1] = 30'h800;  mw[1] = 1'b0; md[1] = 32'h0BAD0BAD; msel[1] = 4'hF;
        mcti[1] = 3'b010;

        @(posedge clk); #1;
        for (int i = 0; i < tbl.size(); i++) begin
            vec_t v;
            v = tbl[i];
            rst = v.rst; mc[0] = v.c0; ms[0] = v.c0; mc[1] = v.c1; ms[1] = v.c1;
            s_ack_i = v.ack; s_busy_i = v.busy;
            @(negedge clk);
            t_exp = {v.g, v.scyc, v.a0, v.a1, v.e0, v.e1,
                     v.scyc ? ((v.g == 2'b01) ? 30'h400 : 30'h800) : 30'h0,
                     v.scyc && (v.g == 2'b01),
                     v.scyc ? ((v.g == 2'b01) ? 32'hDEADBEEF : 32'h0BAD0BAD) : 32'h0,
                     32'hCAFEF00D};
            t_act = {grant, s_cyc_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o,
                     s_addr_o, s_we_o, s_data_o, m0_data_o};
            n_tests++;
            if (t_act !== t_exp || m1_data_o !== 32'hCAFEF00D) begin
                n_fail++;
                $display("FAIL table row %0d: got %h m1d %h, expected %h m1d cafef00d",
                         i, t_act, m1_data_o, t_exp);
            end
            @(posedge clk); #1;
        end

        // Randomized traffic against the behavioural model.
        for (int c = 0; c < 3000; c++) begin
            ack_pct = ((c / 200) % 3 == 0) ? 50 : (((c / 200) % 3 == 1) ? 15 : 2);
            rst = (c == 0) || ($urandom_range(0, 299) == 0);
            for (int x = 0; x < 2; x++) begin
                if (!mc[x]) mc[x] = ($urandom_range(0, 3) == 0);
                else if ($urandom_range(0, 15) == 0) mc[x] = 1'b0;
                ms[x]   = mc[x] && ($urandom_range(0, 7) != 0);
                mw[x]   = 1'($urandom);
                ma[x]   = 30'($urandom);
                mcti[x] = 3'($urandom);
                mbte[x] = 2'($urandom);
                msel[x] = 4'($urandom);
                md[x]   = $urandom;
            end
            s_ack_i  = ($urandom_range(0, 99) < ack_pct);
            s_busy_i = ($urandom_range(0, 3) == 0);
            s_data_i = $urandom;
            @(negedge clk);
            r_exp = model_out();
            r_act = dut_out();
            n_tests++;
            if (r_act !== r_exp) begin
                n_fail++;
                $display("FAIL random cycle %0d: got %h, expected %h", c, r_act, r_exp);
            end
            @(posedge clk);
            model_step();
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
